// File: rtl/core_dbg_pkg.sv
// Shared encodings for the host debug port: command opcodes, FSM states and dump word layout.
// Optional feature macro: CORE_DBG_CHECKSUM_EN (appends an XOR checksum word to the dump).
package core_dbg_pkg;

  localparam logic [1:0] DBG_OP_DUMP    = 2'd0;
  localparam logic [1:0] DBG_OP_WR_GREG = 2'd1;
  localparam logic [1:0] DBG_OP_WR_FREG = 2'd2;
  localparam logic [1:0] DBG_OP_SET_PC  = 2'd3;

  // Word 0 is the PC, then 32 gregs, then 32 fregs.
  localparam logic [6:0] DUMP_WORDS = 7'd65;
  localparam logic [6:0] GREG_BASE  = 7'd1;
  localparam logic [6:0] FREG_BASE  = 7'd33;
  localparam logic [6:0] CSUM_IDX   = 7'd65;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_SEND
  } dbg_state_t;

endpackage

// File: rtl/core_dbg_port.sv
// Host debug initiator: dumps PC + 64 registers as a word stream, writes one register or forces the PC.
// Optional: CORE_DBG_CHECKSUM_EN appends an XOR checksum word after freg31.
module core_dbg_port
  import core_dbg_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter bit SKIP_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_idx,
  input  logic [31:0] cmd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        pcenable,
  output logic [31:0] next_pc,
  input  logic [31:0] pc,
  output logic [4:0]  rgreg1,
  output logic [4:0]  rgreg2,
  input  logic [31:0] greg_out1,
  input  logic [31:0] greg_out2,
  output logic        wgenable,
  output logic [4:0]  wgreg,
  output logic [31:0] wgdata,
  output logic [4:0]  rfreg1,
  output logic [4:0]  rfreg2,
  input  logic [31:0] freg_out1,
  input  logic [31:0] freg_out2,
  output logic        wfenable,
  output logic [4:0]  wfreg,
  output logic [31:0] wfdata
);

`ifdef CORE_DBG_CHECKSUM_EN
  localparam logic [6:0] LAST_IDX = CSUM_IDX;
  logic [31:0] csum;
`else
  localparam logic [6:0] LAST_IDX = DUMP_WORDS - 7'd1;
`endif
  localparam logic [1:0] RD_LAT_W = 2'(RD_LAT);

  dbg_state_t  state;
  logic [6:0]  k;
  logic [6:0]  k_nxt;
  logic [1:0]  wcnt;
  logic        rd_freg;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign k_nxt     = k + 7'd1;
  assign rd_data   = rd_freg ? freg_out1 : greg_out1;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_SEND);
  // Port 2 of each register file is owned by us but never needed for a dump.
  assign unused_ok = ^{greg_out2, freg_out2};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      k        <= '0;
      wcnt     <= '0;
      rd_freg  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      pcenable <= 1'b0;
      next_pc  <= '0;
      wgenable <= 1'b0;
      wgreg    <= '0;
      wgdata   <= '0;
      wfenable <= 1'b0;
      wfreg    <= '0;
      wfdata   <= '0;
      rgreg1   <= '0;
      rgreg2   <= '0;
      rfreg1   <= '0;
      rfreg2   <= '0;
`ifdef CORE_DBG_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      // Strobes are single-cycle: set on accept, dropped when WRITE ends.
      pcenable <= 1'b0;
      wgenable <= 1'b0;
      wfenable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              DBG_OP_DUMP: begin
                state    <= ST_SEND;
                k        <= '0;
                out_data <= pc;
                out_last <= 1'b0;
`ifdef CORE_DBG_CHECKSUM_EN
                csum     <= '0;
`endif
              end
              DBG_OP_WR_GREG: begin
                state    <= ST_WRITE;
                wgenable <= !(SKIP_R0 && (cmd_idx == 5'd0));
                wgreg    <= cmd_idx;
                wgdata   <= cmd_data;
              end
              DBG_OP_WR_FREG: begin
                state    <= ST_WRITE;
                wfenable <= 1'b1;
                wfreg    <= cmd_idx;
                wfdata   <= cmd_data;
              end
              default: begin
                state    <= ST_WRITE;
                pcenable <= 1'b1;
                next_pc  <= cmd_data;
              end
            endcase
          end
        end
        ST_WRITE: state <= ST_IDLE;
        ST_RD_ADDR: begin
          if (RD_LAT == 0) begin
            out_data <= rd_data;
            out_last <= (k == LAST_IDX);
            state    <= ST_SEND;
          end else begin
            wcnt  <= 2'd1;
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (wcnt == RD_LAT_W) begin
            out_data <= rd_data;
            out_last <= (k == LAST_IDX);
            state    <= ST_SEND;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
`ifdef CORE_DBG_CHECKSUM_EN
            csum <= csum ^ out_data;
`endif
            if (k == LAST_IDX) begin
              state    <= ST_IDLE;
              out_last <= 1'b0;
`ifdef CORE_DBG_CHECKSUM_EN
            end else if (k_nxt == CSUM_IDX) begin
              k        <= k_nxt;
              out_data <= csum ^ out_data;
              out_last <= 1'b1;
`endif
            end else begin
              k       <= k_nxt;
              rd_freg <= (k_nxt >= FREG_BASE);
              if (k_nxt < FREG_BASE) begin
                rgreg1 <= 5'(k_nxt - GREG_BASE);
                rgreg2 <= 5'(k_nxt - GREG_BASE);
              end else begin
                rfreg1 <= 5'(k_nxt - FREG_BASE);
                rfreg2 <= 5'(k_nxt - FREG_BASE);
              end
              state <= ST_RD_ADDR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/core_dbg_port.md
Name: core_dbg_port

Overview:
- Host-side debug initiator that owns the core's PC and register-file access ports: pcenable/next_pc, the greg/freg read and write ports.
- Accepts single-beat commands from a host link (UART/loader side):
  - dump PC and all 64 architectural registers as a 32-bit word stream;
  - write one greg or one freg;
  - force the PC.
- Sits between the loader/UART block and the core, and drives the core's ports only while `busy` is high.

Parameters:
- RD_LAT, 1, cycles from a read address being driven to `greg_out1`/`freg_out1` being valid (0..3; 0 = combinational read).
- SKIP_R0, 1, when 1, writes to greg 0 are dropped. The command is still accepted and completes normally.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=DUMP, 1=WR_GREG, 2=WR_FREG, 3=SET_PC
- cmd_idx  in  5  register index (WR_GREG/WR_FREG)
- cmd_data  in  32  write data / new PC
- out_valid  out  1  dump word valid
- out_ready  in  1  host accepts word
- out_data  out  32  dump word
- out_last  out  1  final word of dump
- busy  out  1  command in progress
- pcenable  out  1  PC load strobe
- next_pc  out  32  PC load value
- pc  in  32  current PC
- rgreg1, rgreg2  out  5  greg read addresses
- greg_out1, greg_out2  in  32  greg read data
- wgenable  out  1  greg write strobe
- wgreg  out  5  greg write index
- wgdata  out  32  greg write data
- rfreg1, rfreg2  out  5  freg read addresses
- freg_out1, freg_out2  in  32  freg read data
- wfenable  out  1  freg write strobe
- wfreg  out  5  freg write index
- wfdata  out  32  freg write data

Behaviour:
- Reset (rstn low at posedge) state:
  - FSM goes to IDLE.
  - Outputs: cmd_ready=1, busy=0, out_valid=0, out_last=0, out_data=0.
  - All strobes 0; all addresses 0; next_pc, wgdata and wfdata are 0.
  - Reset mid-dump or mid-write aborts the command immediately; no partial stream word stays valid.
- FSM states: IDLE, WRITE, RD_ADDR, RD_WAIT, SEND.
  - cmd_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE, on accept:
  - WR_GREG/WR_FREG/SET_PC → WRITE.
  - DUMP → SEND, word index k=0, out_data=pc captured at the accept edge.
- WRITE (exactly 1 cycle):
  - Exactly one strobe is high: wgenable, wfenable or pcenable.
  - Index and data are the registered command fields.
  - WR_GREG with idx 0 and SKIP_R0=1: wgenable stays 0.
  - Next state is IDLE.
  - Accept-to-strobe latency is 1 cycle.
- Dump word order:
  - k=0 is the PC.
  - k=1..32 are greg 0..31.
  - k=33..64 are freg 0..31.
  - 65 words total.
  - out_last=1 only on k=64 (or k=65 under the optional feature).
- RD_ADDR:
  - Drive rgreg1=rgreg2=k-1 (greg phase) or rfreg1=rfreg2=k-33 (freg phase).
  - With RD_LAT=0: capture the read data the same cycle and go → SEND.
  - Otherwise → RD_WAIT.
- RD_WAIT:
  - Hold the address for RD_LAT cycles, then capture port-1 data → SEND.
  - Port-2 data is ignored.
- SEND:
  - out_valid=1.
  - out_data/out_last stay stable until out_valid && out_ready.
  - On handshake:
    - k increments;
    - if the last word was sent → IDLE with out_valid=0 the following cycle;
    - else → RD_ADDR.
  - No bubble-free requirement: throughput is at least one word per (RD_LAT+2) cycles.
- While busy:
  - cmd_valid is ignored; cmd_ready=0.
  - Read addresses hold their last value when not in RD_ADDR/RD_WAIT.
- The index counter is 7 bits and does not wrap past the last word.

Optional Feature:
- CORE_DBG_CHECKSUM_EN defined:
  - The dump appends word k=65 = XOR of words 0..64, computed incrementally on each handshake.
  - out_last moves to k=65; the dump is 66 words.
  - The checksum accumulator clears on DUMP accept.
- Undefined: the dump is 65 words, with no accumulator logic.

Decomposition:
- Shared package `core_dbg_pkg`:
  - cmd_op encoding constants (DBG_OP_DUMP=0, DBG_OP_WR_GREG=1, DBG_OP_WR_FREG=2, DBG_OP_SET_PC=3);
  - FSM state typedef;
  - DUMP_WORDS=65 and word-index boundary constants (GREG_BASE=1, FREG_BASE=33).
- Sub-module: none. The FSM plus datapath is a single module (~200 lines).

Test Plan:
- WR_GREG idx=5 data=0xDEADBEEF → one cycle after accept: wgenable=1, wgreg=5, wgdata=0xDEADBEEF; next cycle wgenable=0, cmd_ready=1.
- WR_GREG idx=0 data=0x1 with SKIP_R0=1 → command accepted, busy for 1 cycle, wgenable never high.
- SET_PC data=0x00000100 → pcenable pulses 1 cycle with next_pc=0x100; later DUMP word 0 equals the core's pc (0x100).
- Preload greg i=i*3 and freg i=0x3F800000+i, then DUMP with out_ready=1, RD_LAT=1 → 65 words in the specified order, out_last only on word 64 (freg31=0x3F80001F).
- DUMP with out_ready toggling 1-of-3 cycles → out_data stable while stalled; no word lost or duplicated; cmd_valid during the dump is not accepted.
- rstn low during the dump at word 20 → next cycle out_valid=0, busy=0, cmd_ready=1; a new DUMP restarts at word 0 (PC). With CORE_DBG_CHECKSUM_EN defined, word 65 equals the XOR of words 0..64.
